// File: rtl/simple_cpu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : simple_cpu_pkg
//  Description : Shared encodings for the simple CPU memory path: arbiter
//                FSM state codes, transaction owner codes and default bus
//                widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package simple_cpu_pkg;

    localparam int unsigned DEF_ADDR_W = 32;
    localparam int unsigned DEF_DATA_W = 32;

    // Arbiter FSM state encoding
    localparam int unsigned STATE_W = 2;
    localparam logic [STATE_W-1:0] IDLE = 2'd0;
    localparam logic [STATE_W-1:0] REQ  = 2'd1;
    localparam logic [STATE_W-1:0] RESP = 2'd2;

    // Owner of the in-flight transaction
    localparam logic OWN_INST = 1'b0;
    localparam logic OWN_DATA = 1'b1;

endpackage
`default_nettype wire

// File: rtl/simple_mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : simple_mem_arbiter_if
//  Description : Bundle of every handshake/bus signal around the memory
//                arbiter: fetch request, load/store request, shared response
//                data and the downstream memory port.
//  Modports    : master - arbiter side (answers requesters, drives memory)
//                slave  - environment side (CPU requesters and memory)
//  Revision    : 1.0 - initial release
// ============================================================================
interface simple_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // Fetch requester
    logic                  inst_req_valid;
    logic                  inst_req_ready;
    logic [ADDR_W-1:0]     inst_addr;
    logic                  inst_rsp_valid;
    // Load/store requester
    logic                  data_req_valid;
    logic                  data_req_ready;
    logic [ADDR_W-1:0]     data_addr;
    logic                  data_wen;
    logic [DATA_W/8-1:0]   data_wstrb;
    logic [DATA_W-1:0]     data_wdata;
    logic                  data_rsp_valid;
    // Shared response data
    logic [DATA_W-1:0]     rsp_rdata;
    // Downstream memory port
    logic                  mem_req_valid;
    logic                  mem_req_ready;
    logic [ADDR_W-1:0]     mem_addr;
    logic                  mem_wen;
    logic [DATA_W/8-1:0]   mem_wstrb;
    logic [DATA_W-1:0]     mem_wdata;
    logic                  mem_rdata_valid;
    logic [DATA_W-1:0]     mem_rdata;
    logic                  mem_rdata_ready;

    modport master (
        input  inst_req_valid, inst_addr,
        input  data_req_valid, data_addr, data_wen, data_wstrb, data_wdata,
        input  mem_req_ready, mem_rdata_valid, mem_rdata,
        output inst_req_ready, inst_rsp_valid,
        output data_req_ready, data_rsp_valid, rsp_rdata,
        output mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
        output mem_rdata_ready
    );

    modport slave (
        output inst_req_valid, inst_addr,
        output data_req_valid, data_addr, data_wen, data_wstrb, data_wdata,
        output mem_req_ready, mem_rdata_valid, mem_rdata,
        input  inst_req_ready, inst_rsp_valid,
        input  data_req_ready, data_rsp_valid, rsp_rdata,
        input  mem_req_valid, mem_addr, mem_wen, mem_wstrb, mem_wdata,
        input  mem_rdata_ready
    );

endinterface
`default_nettype wire

// File: rtl/rr_grant2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant2
//  Description : Two-way round-robin chooser between the fetch and the
//                load/store requester.
//  Ports       : inst_valid  - fetch requester valid
//                data_valid  - load/store requester valid
//                last_data   - 1 when the previous grant went to load/store
//                grant_data  - 1 selects load/store, 0 selects fetch
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant2 (
    input  logic inst_valid,
    input  logic data_valid,
    input  logic last_data,
    output logic grant_data
);

    // Data wins when it is alone, or on a tie when fetch was served last.
    always_comb begin
        grant_data = data_valid && (!inst_valid || !last_data);
    end

endmodule
`default_nettype wire

// File: rtl/simple_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : simple_mem_arbiter
//  Description : Shares one memory port between the instruction-fetch and
//                load/store requesters. One transaction at a time, round-robin
//                on ties. Stores complete without a response pulse; loads and
//                fetches return registered data on rsp_rdata with a one-cycle
//                pulse on the owner's *_rsp_valid.
//  Ports       : clk - rising-edge clock
//                rst - asynchronous active-high reset
//                bus - simple_mem_arbiter_if.master (all request/response
//                      and downstream memory signals)
//  Revision    : 1.0 - initial release
// ============================================================================
module simple_mem_arbiter
    import simple_cpu_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                 clk,
    input  logic                 rst,
    simple_mem_arbiter_if.master bus
);

    localparam int STRB_W = DATA_W / 8;

    logic [STATE_W-1:0] state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_data_q, last_data_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic               wen_q, wen_d;
    logic [STRB_W-1:0]  wstrb_q, wstrb_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
    logic               inst_rsp_valid_q, inst_rsp_valid_d;
    logic               data_rsp_valid_q, data_rsp_valid_d;

    logic grant_data;
    logic any_valid;
    logic accept;

    rr_grant2 u_rr_grant2 (
        .inst_valid (bus.inst_req_valid),
        .data_valid (bus.data_req_valid),
        .last_data  (last_data_q),
        .grant_data (grant_data)
    );

    always_comb begin
        any_valid = bus.inst_req_valid || bus.data_req_valid;
        accept    = (state_q == IDLE) && any_valid;
    end

    // ---------------- state register (plus datapath flops) -----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q          <= IDLE;
            owner_q          <= OWN_INST;
            last_data_q      <= 1'b1;
            addr_q           <= '0;
            wen_q            <= 1'b0;
            wstrb_q          <= '0;
            wdata_q          <= '0;
            rsp_rdata_q      <= '0;
            inst_rsp_valid_q <= 1'b0;
            data_rsp_valid_q <= 1'b0;
        end else begin
            state_q          <= state_d;
            owner_q          <= owner_d;
            last_data_q      <= last_data_d;
            addr_q           <= addr_d;
            wen_q            <= wen_d;
            wstrb_q          <= wstrb_d;
            wdata_q          <= wdata_d;
            rsp_rdata_q      <= rsp_rdata_d;
            inst_rsp_valid_q <= inst_rsp_valid_d;
            data_rsp_valid_q <= data_rsp_valid_d;
        end
    end

    // ---------------- next-state logic --------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (any_valid)           state_d = REQ;
            // Stores finish at the request handshake; reads wait for data.
            REQ:     if (bus.mem_req_ready)   state_d = wen_q ? IDLE : RESP;
            RESP:    if (bus.mem_rdata_valid) state_d = IDLE;
            default:                          state_d = IDLE;
        endcase
    end

    // ---------------- datapath next values ----------------------------------
    always_comb begin
        owner_d          = owner_q;
        last_data_d      = last_data_q;
        addr_d           = addr_q;
        wen_d            = wen_q;
        wstrb_d          = wstrb_q;
        wdata_d          = wdata_q;
        rsp_rdata_d      = rsp_rdata_q;
        inst_rsp_valid_d = 1'b0;
        data_rsp_valid_d = 1'b0;

        if (accept) begin
            owner_d     = grant_data ? OWN_DATA : OWN_INST;
            last_data_d = grant_data;
            if (grant_data) begin
                addr_d  = bus.data_addr;
                wen_d   = bus.data_wen;
                wstrb_d = bus.data_wstrb;
                wdata_d = bus.data_wdata;
            end else begin
                // Fetches are always reads with no byte lanes enabled.
                addr_d  = bus.inst_addr;
                wen_d   = 1'b0;
                wstrb_d = '0;
                wdata_d = '0;
            end
        end

        if ((state_q == RESP) && bus.mem_rdata_valid) begin
            rsp_rdata_d      = bus.mem_rdata;
            inst_rsp_valid_d = (owner_q == OWN_INST);
            data_rsp_valid_d = (owner_q == OWN_DATA);
        end
    end

    // ---------------- outputs -----------------------------------------------
    always_comb begin
        // Gated by rst so no requester sees a grant while reset is held.
        bus.inst_req_ready  = !rst && accept && !grant_data;
        bus.data_req_ready  = !rst && accept &&  grant_data;
        bus.mem_req_valid   = (state_q == REQ);
        bus.mem_rdata_ready = (state_q == RESP);
        bus.mem_addr        = addr_q;
        bus.mem_wen         = wen_q;
        bus.mem_wstrb       = wstrb_q;
        bus.mem_wdata       = wdata_q;
        bus.rsp_rdata       = rsp_rdata_q;
        bus.inst_rsp_valid  = inst_rsp_valid_q;
        bus.data_rsp_valid  = data_rsp_valid_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_simple_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_simple_mem_arbiter
//  Description : Self-checking bench for simple_mem_arbiter: a cycle table
//                for fetch and store traffic, then directed sequences for
//                round-robin ties, backpressure and reset mid-transaction.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_simple_mem_arbiter;

    logic clk;
    logic rst;

    simple_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    simple_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [31:0] da;
        logic        dwen;
        logic [3:0]  dstrb;
        logic [31:0] dwd;
        logic        mrr;
        logic        mrv;
        logic [31:0] mrd;
    } stim_t;

    typedef struct {
        logic        irdy;
        logic        drdy;
        logic        mval;
        logic        chk;     // compare the mem_* request fields
        logic [31:0] maddr;
        logic        mwen;
        logic [3:0]  mstrb;
        logic [31:0] mwd;
        logic        rrdy;
        logic        irsp;
        logic        drsp;
        logic [31:0] rdata;
    } exp_t;

    typedef struct {
        stim_t s;
        exp_t  e;
    } vec_t;

    vec_t tv[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic add_vec(input stim_t s, input exp_t e);
        vec_t v;
        v.s = s;
        v.e = e;
        tv.push_back(v);
    endtask

    task automatic drive(input stim_t s);
        bus.inst_req_valid  = s.iv;
        bus.inst_addr       = s.ia;
        bus.data_req_valid  = s.dv;
        bus.data_addr       = s.da;
        bus.data_wen        = s.dwen;
        bus.data_wstrb      = s.dstrb;
        bus.data_wdata      = s.dwd;
        bus.mem_req_ready   = s.mrr;
        bus.mem_rdata_valid = s.mrv;
        bus.mem_rdata       = s.mrd;
    endtask

    task automatic clear_inputs();
        drive('{1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0, 1'b0, 32'h0});
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;
    endtask

    int gq[$];
    int rq[$];

    initial begin
        rst = 1'b0;
        clear_inputs();
        #1 rst = 1'b1;
        bus.inst_req_valid = 1'b1;
        bus.data_req_valid = 1'b1;

        // ---------------- reset state ----------------
        @(negedge clk);
        #1;
        chk("reset inst_req_ready",  bus.inst_req_ready,  0);
        chk("reset data_req_ready",  bus.data_req_ready,  0);
        chk("reset mem_req_valid",   bus.mem_req_valid,   0);
        chk("reset mem_rdata_ready", bus.mem_rdata_ready, 0);
        chk("reset mem_addr",        bus.mem_addr,        0);
        chk("reset rsp_rdata",       bus.rsp_rdata,       0);
        chk("reset inst_rsp_valid",  bus.inst_rsp_valid,  0);
        chk("reset data_rsp_valid",  bus.data_rsp_valid,  0);
        clear_inputs();
        @(negedge clk);
        rst = 1'b0;

        // ---------------- cycle table: fetch, store, zero-strobe store -----
        //          iv  ia          dv  da         wen strb  wdata        mrr mrv mrd
        //          irdy drdy mval chk maddr      wen strb wdata        rrdy irsp drsp rdata
        // Fetch 0x100, memory answers at once; mem_rdata_valid in IDLE/REQ is ignored.
        add_vec('{1, 32'h100, 0, 32'h0,  0, 4'h0, 32'h0,        1, 1, 32'h12345678},
                '{1, 0, 0, 0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 32'h0});
        add_vec('{0, 32'h0,   0, 32'h0,  0, 4'h0, 32'h0,        1, 1, 32'h12345678},
                '{0, 0, 1, 1, 32'h100, 0, 4'h0, 32'h0,        0, 0, 0, 32'h0});
        add_vec('{0, 32'h0,   0, 32'h0,  0, 4'h0, 32'h0,        1, 1, 32'h12345678},
                '{0, 0, 0, 1, 32'h100, 0, 4'h0, 32'h0,        1, 0, 0, 32'h0});
        add_vec('{0, 32'h0,   0, 32'h0,  0, 4'h0, 32'h0,        0, 0, 32'h0},
                '{0, 0, 0, 0, 32'h0,   0, 4'h0, 32'h0,        0, 1, 0, 32'h12345678});
        add_vec('{0, 32'h0,   0, 32'h0,  0, 4'h0, 32'h0,        0, 0, 32'h0},
                '{0, 0, 0, 0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 32'h12345678});
        // Store 0x0C, ready held low one cycle; no response pulse.
        add_vec('{0, 32'h0,   1, 32'h0C, 1, 4'hF, 32'h0,        0, 0, 32'h0},
                '{0, 1, 0, 0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 32'h12345678});
        add_vec('{0, 32'h0,   0, 32'h0,  0, 4'h0, 32'h0,        0, 0, 32'h0},
                '{0, 0, 1, 1, 32'h0C,  1, 4'hF, 32'h0,        0, 0, 0, 32'h12345678});
        add_vec('{0, 32'h0,   0, 32'h0,  0, 4'h0, 32'h0,        1, 0, 32'h0},
                '{0, 0, 1, 1, 32'h0C,  1, 4'hF, 32'h0,        0, 0, 0, 32'h12345678});
        // Back in IDLE right away: a new store with wstrb=0 is granted.
        add_vec('{0, 32'h0,   1, 32'h20, 1, 4'h0, 32'hCAFEF00D, 0, 0, 32'h0},
                '{0, 1, 0, 0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 32'h12345678});
        add_vec('{0, 32'h0,   0, 32'h0,  0, 4'h0, 32'h0,        1, 0, 32'h0},
                '{0, 0, 1, 1, 32'h20,  1, 4'h0, 32'hCAFEF00D, 0, 0, 0, 32'h12345678});
        add_vec('{0, 32'h0,   0, 32'h0,  0, 4'h0, 32'h0,        0, 0, 32'h0},
                '{0, 0, 0, 0, 32'h0,   0, 4'h0, 32'h0,        0, 0, 0, 32'h12345678});

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].s);
            #1;
            chk($sformatf("v%0d inst_req_ready", i),  bus.inst_req_ready,  tv[i].e.irdy);
            chk($sformatf("v%0d data_req_ready", i),  bus.data_req_ready,  tv[i].e.drdy);
            chk($sformatf("v%0d mem_req_valid", i),   bus.mem_req_valid,   tv[i].e.mval);
            chk($sformatf("v%0d mem_rdata_ready", i), bus.mem_rdata_ready, tv[i].e.rrdy);
            chk($sformatf("v%0d inst_rsp_valid", i),  bus.inst_rsp_valid,  tv[i].e.irsp);
            chk($sformatf("v%0d data_rsp_valid", i),  bus.data_rsp_valid,  tv[i].e.drsp);
            chk($sformatf("v%0d rsp_rdata", i),       bus.rsp_rdata,       tv[i].e.rdata);
            if (tv[i].e.chk) begin
                chk($sformatf("v%0d mem_addr", i),  bus.mem_addr,  tv[i].e.maddr);
                chk($sformatf("v%0d mem_wen", i),   bus.mem_wen,   tv[i].e.mwen);
                chk($sformatf("v%0d mem_wstrb", i), bus.mem_wstrb, tv[i].e.mstrb);
                chk($sformatf("v%0d mem_wdata", i), bus.mem_wdata, tv[i].e.mwd);
            end
        end

        // ---------------- tie: both valid for 4 transactions after reset ---
        reset_dut();
        bus.inst_addr       = 32'h200;
        bus.data_addr       = 32'h300;
        bus.data_wen        = 1'b0;
        bus.mem_req_ready   = 1'b1;
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 32'h0BADF00D;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.inst_req_valid = (gq.size() < 4);
            bus.data_req_valid = (gq.size() < 4);
            #1;
            chk($sformatf("tie c%0d one-hot ready", c), bus.inst_req_ready & bus.data_req_ready, 0);
            if (bus.inst_req_ready)      gq.push_back(0);
            else if (bus.data_req_ready) gq.push_back(1);
            if (bus.inst_rsp_valid) rq.push_back(0);
            if (bus.data_rsp_valid) rq.push_back(1);
        end
        chk("tie grant count", gq.size(), 4);
        chk("tie rsp count",   rq.size(), 4);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("tie grant %0d owner", k), (k < gq.size()) ? gq[k] : 9, k % 2);
            chk($sformatf("tie rsp %0d owner", k),   (k < rq.size()) ? rq[k] : 9, k % 2);
        end
        chk("tie rsp_rdata", bus.rsp_rdata, 32'h0BADF00D);

        // ---------------- backpressure on a load to 0x40 -------------------
        clear_inputs();
        @(negedge clk);
        bus.data_req_valid = 1'b1;
        bus.data_addr      = 32'h40;
        #1;
        chk("bp load granted", bus.data_req_ready, 1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (c == 0) begin
                // Both requesters pester the arbiter while it is stalled.
                bus.inst_req_valid = 1'b1;
                bus.inst_addr      = 32'h600;
                bus.data_addr      = 32'h44;
            end
            #1;
            chk($sformatf("bp c%0d mem_req_valid", c),  bus.mem_req_valid,  1);
            chk($sformatf("bp c%0d mem_addr", c),       bus.mem_addr,       32'h40);
            chk($sformatf("bp c%0d mem_wen", c),        bus.mem_wen,        0);
            chk($sformatf("bp c%0d inst_req_ready", c), bus.inst_req_ready, 0);
            chk($sformatf("bp c%0d data_req_ready", c), bus.data_req_ready, 0);
        end
        @(negedge clk);
        bus.inst_req_valid = 1'b0;
        bus.data_req_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        #1;
        chk("bp release mem_addr", bus.mem_addr, 32'h40);
        @(negedge clk);
        bus.mem_req_ready   = 1'b0;
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 32'hDEADBEEF;
        #1;
        chk("bp mem_rdata_ready", bus.mem_rdata_ready, 1);
        @(negedge clk);
        bus.mem_rdata_valid = 1'b0;
        #1;
        chk("bp data_rsp_valid", bus.data_rsp_valid, 1);
        chk("bp inst_rsp_valid", bus.inst_rsp_valid, 0);
        chk("bp rsp_rdata",      bus.rsp_rdata,      32'hDEADBEEF);

        // ---------------- reset while in RESP -------------------------------
        @(negedge clk);
        bus.inst_req_valid = 1'b1;
        bus.inst_addr      = 32'h500;
        #1;
        chk("rmid fetch granted", bus.inst_req_ready, 1);
        @(negedge clk);
        bus.inst_req_valid = 1'b0;
        bus.mem_req_ready  = 1'b1;
        #1;
        chk("rmid mem_req_valid", bus.mem_req_valid, 1);
        @(negedge clk);
        bus.mem_req_ready = 1'b0;
        #1;
        chk("rmid in RESP", bus.mem_rdata_ready, 1);
        #2 rst = 1'b1;
        bus.mem_rdata_valid = 1'b1;
        bus.mem_rdata       = 32'h77777777;
        #1;
        chk("rmid async mem_rdata_ready", bus.mem_rdata_ready, 0);
        chk("rmid async mem_req_valid",   bus.mem_req_valid,   0);
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            #1;
            chk($sformatf("rmid c%0d inst_rsp_valid", c), bus.inst_rsp_valid, 0);
            chk($sformatf("rmid c%0d data_rsp_valid", c), bus.data_rsp_valid, 0);
            chk($sformatf("rmid c%0d rsp_rdata", c),      bus.rsp_rdata,      0);
        end
        @(negedge clk);
        rst = 1'b0;
        bus.mem_rdata_valid = 1'b0;
        bus.inst_req_valid  = 1'b1;
        bus.data_req_valid  = 1'b1;
        #1;
        chk("rmid tie inst_req_ready", bus.inst_req_ready, 1);
        chk("rmid tie data_req_ready", bus.data_req_ready, 0);

        clear_inputs();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/simple_mem_arbiter.md
Name: simple_mem_arbiter

Overview:
- Shares the multi-cycle CPU's single memory port between the instruction-fetch requester and the load/store requester.
- Sits between the simple CPU core and the memory/AXI bridge inside the simple CPU top.
- Issues one transaction at a time, with valid/ready handshakes on every side.
- Arbitrates round-robin when both requesters are valid, so neither starves.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width; strobe width is DATA_W/8

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
inst_req_valid  in  1  fetch request valid
inst_req_ready  out  1  fetch request accepted this cycle
inst_addr  in  ADDR_W  fetch address
inst_rsp_valid  out  1  one-cycle pulse: fetch data on rsp_rdata
data_req_valid  in  1  load/store request valid
data_req_ready  out  1  load/store request accepted this cycle
data_addr  in  ADDR_W  load/store address
data_wen  in  1  1 = store, 0 = load
data_wstrb  in  DATA_W/8  store byte strobes
data_wdata  in  DATA_W  store data
data_rsp_valid  out  1  one-cycle pulse: load data on rsp_rdata
rsp_rdata  out  DATA_W  registered read data, shared by both responses
mem_req_valid  out  1  downstream request valid
mem_req_ready  in  1  downstream request accepted
mem_addr  out  ADDR_W  downstream address
mem_wen  out  1  downstream write enable
mem_wstrb  out  DATA_W/8  downstream strobes
mem_wdata  out  DATA_W  downstream write data
mem_rdata_valid  in  1  downstream read data valid
mem_rdata  in  DATA_W  downstream read data
mem_rdata_ready  out  1  arbiter ready for read data

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Round-robin pointer last_data = 1, so the fetch requester wins the first tie.
- FSM, states IDLE, REQ, RESP:
  - IDLE: a grant is made when any requester is valid.
    - Both valid: grant the requester not recorded in last_data.
    - One valid: grant that one.
    - The granted *_req_ready is combinational and high only in IDLE.
    - On the accept edge: latch addr/wen/wstrb/wdata (fetch forces wen=0, wstrb=0), record the owner, update last_data, then go to REQ.
  - REQ: mem_req_valid=1; mem_addr/wen/wstrb/wdata come from the latched registers.
    - These outputs stay stable until mem_req_ready.
    - On mem_req_ready: a store goes to IDLE (store complete, no response pulse); a load or fetch goes to RESP.
  - RESP: mem_rdata_ready=1.
    - On mem_rdata_valid: register mem_rdata into rsp_rdata, pulse the owner's *_rsp_valid on the next cycle, go to IDLE.
- Latency:
  - Request accepted at cycle T gives mem_req_valid at T+1.
  - Read data at cycle R gives rsp pulse at R+1.
  - Best-case fetch round trip is 3 cycles.
- A new grant is allowed in the same cycle as the rsp pulse.
- rsp_rdata holds its value until the next response.
- *_req_ready is never high outside IDLE, and at most one *_req_ready is high per cycle.
- mem_rdata_valid outside RESP is ignored.
- A requester that deasserts valid before it is granted is simply not served; there is no latching.
- A store with data_wstrb=0 is still forwarded unchanged.
- Reset mid-transaction:
  - Asynchronous return to IDLE; mem_req_valid and mem_rdata_ready drop immediately.
  - The in-flight transaction is dropped with no response pulse.
  - last_data returns to 1.

Decomposition:
- Shared package `simple_cpu_pkg`: state encoding (IDLE/REQ/RESP localparams), the owner encoding (OWN_INST=0, OWN_DATA=1), ADDR_W/DATA_W defaults.
- One natural sub-module, `rr_grant2`: the 2-way round-robin chooser. Inputs are the two valids plus last_data; output is grant_data.

Test Plan:
- Fetch only:
  - Stimulus: inst_addr=0x100 with mem_req_ready and mem_rdata_valid returned immediately, mem_rdata=0x12345678.
  - Required: inst_req_ready at T, mem_addr=0x100 at T+1, inst_rsp_valid with rsp_rdata=0x12345678 at T+3.
- Store:
  - Stimulus: data_addr=0x0C, wen=1, wstrb=0xF, wdata=0.
  - Required: mem_wen=1, mem_addr=0x0C, mem_wdata=0 held until ready; no data_rsp_valid pulse; back in IDLE the next cycle.
- Tie sequence:
  - Stimulus: both requesters held valid for 4 transactions after reset.
  - Required: grants in the order inst, data, inst, data.
- Backpressure:
  - Stimulus: mem_req_ready held low 5 cycles on a load to 0x40.
  - Required: mem_req_valid/mem_addr stable all 5 cycles; both *_req_ready remain 0.
- Reset mid-transaction:
  - Stimulus: rst asserted while in RESP.
  - Required: mem_rdata_ready drops asynchronously; no rsp pulse; the first tie after reset grants inst.
